microdisc_sd_bridge: RTL



---
 rtl/microdisc_pkg.sv | 26 ++
 rtl/microdisc_sd_bridge_if.sv | 21 ++
 rtl/microdisc_sd_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/microdisc_pkg.sv
// Shared types and constants for the Microdisc sector bridge.
package microdisc_pkg;

    localparam int unsigned SECTOR_BYTES      = 512;
    localparam int unsigned SECTOR_SHIFT      = 9;
    localparam logic [7:0]  FILL_BYTE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        RD_REQ,
        RD_STB,
        WR_ADDR,
        WR_SAMP,
        WR_REQ,
        DONE
    } sd_bridge_state_t;

    // One bit wider than 41 so lba=0xFFFFFFFF cannot wrap to an in-range result.
    function automatic logic sector_in_range(input logic [31:0] lba, input logic [31:0] size);
        logic [41:0] end_b;
        end_b = (42'(lba) + 42'd1) << SECTOR_SHIFT;
        return end_b <= 42'(size);
    endfunction

endpackage

// File: rtl/microdisc_sd_bridge_if.sv
// Byte-wide request/acknowledge bus to the SDRAM-backed disk-image store.
interface microdisc_sd_bridge_if #(
    parameter int unsigned MEM_AW = 20
);
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_req,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_req,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/microdisc_sd_bridge.sv
// Moves 512-byte sectors between the Microdisc FDC sd_* port and the image store.
// Optional write protection via `define MICRODISC_SD_WP_EN (adds img_wp input).
module microdisc_sd_bridge
    import microdisc_pkg::*;
#(
    parameter int unsigned MEM_AW    = 20,
    parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic        CLK_SYS,
    input  logic        RESET,
    input  logic [31:0] img_size,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_dout,
    output logic        sd_dout_strobe,
    input  logic [7:0]  sd_din,
    output logic        sd_din_strobe,
`ifdef MICRODISC_SD_WP_EN
    input  logic        img_wp,
`endif
    microdisc_sd_bridge_if.master mem
);

    sd_bridge_state_t   state_q, state_d;
    logic               wr_q, wr_d;
    logic               in_range_q, in_range_d;
    logic [MEM_AW-10:0] blk_q, blk_d;
    logic [8:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               mem_en;
    logic               last_byte;

`ifdef MICRODISC_SD_WP_EN
    logic wp_q, wp_d;
    assign mem_en = in_range_q && !(wr_q && wp_q);
`else
    assign mem_en = in_range_q;
`endif

    assign last_byte     = (idx_q == 9'(SECTOR_BYTES - 1));
    assign sd_buff_addr  = idx_q;
    assign sd_dout       = data_q;
    assign mem.mem_addr  = {blk_q, idx_q};
    assign mem.mem_we    = wr_q;
    assign mem.mem_wdata = data_q;

    always_ff @(posedge CLK_SYS or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            in_range_q <= 1'b0;
            blk_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
`ifdef MICRODISC_SD_WP_EN
            wp_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            in_range_q <= in_range_d;
            blk_q      <= blk_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
`ifdef MICRODISC_SD_WP_EN
            wp_q       <= wp_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        in_range_d     = in_range_q;
        blk_d          = blk_q;
        idx_d          = idx_q;
        data_d         = data_q;
`ifdef MICRODISC_SD_WP_EN
        wp_d           = wp_q;
`endif
        sd_ack         = 1'b0;
        sd_dout_strobe = 1'b0;
        sd_din_strobe  = 1'b0;
        mem.mem_req    = 1'b0;

        case (state_q)
            IDLE: begin
                // Request fields are captured on the accepting edge so later changes are ignored.
                if (sd_rd || sd_wr) begin
                    wr_d       = !sd_rd;
                    blk_d      = sd_lba[MEM_AW-10:0];
                    in_range_d = sector_in_range(sd_lba, img_size);
`ifdef MICRODISC_SD_WP_EN
                    wp_d       = img_wp;
`endif
                    state_d    = ACCEPT;
                end
            end
            ACCEPT: begin
                sd_ack  = 1'b1;
                idx_d   = '0;
                state_d = wr_q ? WR_ADDR : RD_REQ;
            end
            RD_REQ: begin
                sd_ack = 1'b1;
                if (mem_en) begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ack) begin
                        data_d  = mem.mem_rdata;
                        state_d = RD_STB;
                    end
                end else begin
                    data_d  = FILL_BYTE;
                    state_d = RD_STB;
                end
            end
            RD_STB: begin
                sd_ack         = 1'b1;
                sd_dout_strobe = 1'b1;
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                sd_ack  = 1'b1;
                state_d = WR_SAMP;
            end
            WR_SAMP: begin
                sd_ack        = 1'b1;
                sd_din_strobe = 1'b1;
                data_d        = sd_din;
                state_d       = WR_REQ;
            end
            WR_REQ: begin
                sd_ack      = 1'b1;
                mem.mem_req = mem_en;
                if (!mem_en || mem.mem_ack) begin
                    if (last_byte) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        state_d = WR_ADDR;
                    end
                end
            end
            DONE: begin
                if (!sd_rd && !sd_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
